ofm_pool_requant: RTL and testbench



---
 rtl/ofm_pool_requant.sv | 94 +++++++++
 tb/tb_ofm_pool_requant.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ofm_pool_requant.sv
// 2x2 stride-2 max pooling over a row-major MAP_W x MAP_W feature map stream,
// followed by logical right shift and unsigned saturation to OUT_WIDTH bits.
module ofm_pool_requant #(
  parameter int IN_WIDTH  = 36,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 8,
  parameter int MAP_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  In_OFM,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] Out_Pool,
  output logic                 frame_done
);

  localparam int CW = $clog2(MAP_W);
  localparam int PW = $clog2(MAP_W / 2);
  localparam int NP = MAP_W / 2;

  function automatic logic [IN_WIDTH-1:0] max2(input logic [IN_WIDTH-1:0] a,
                                                input logic [IN_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [OUT_WIDTH-1:0] requant(input logic [IN_WIDTH-1:0] m);
    logic [IN_WIDTH-1:0] s;
    s = m >> SHIFT;
    if (|s[IN_WIDTH-1:OUT_WIDTH]) return '1;
    return s[OUT_WIDTH-1:0];
  endfunction

  logic [CW-1:0]        col_q, col_d, row_q, row_d;
  logic [IN_WIDTH-1:0]  pair_q, pair_d;
  logic [IN_WIDTH-1:0]  rowbuf_q [NP];
  logic [IN_WIDTH-1:0]  rowbuf_d [NP];
  logic                 vld_q, vld_d, done_q, done_d;
  logic [OUT_WIDTH-1:0] pool_q, pool_d;
  logic [PW-1:0]        idx;
  logic                 last_col;

  assign idx      = PW'(col_q >> 1);
  assign last_col = (col_q == CW'(MAP_W - 1));

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    pair_d   = pair_q;
    rowbuf_d = rowbuf_q;
    vld_d    = 1'b0;
    pool_d   = '0;
    done_d   = 1'b0;
    if (in_valid) begin
      col_d = last_col ? '0 : col_q + CW'(1);
      if (last_col) row_d = (row_q == CW'(MAP_W - 1)) ? '0 : row_q + CW'(1);
      if (!col_q[0]) begin
        pair_d = In_OFM;
      end else if (!row_q[0]) begin
        rowbuf_d[idx] = max2(pair_q, In_OFM);
      end else begin
        // Bottom-right corner of a window: pooled result leaves next cycle.
        vld_d  = 1'b1;
        pool_d = requant(max2(rowbuf_q[idx], max2(pair_q, In_OFM)));
        done_d = last_col && (row_q == CW'(MAP_W - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      pair_q <= '0;
      for (int i = 0; i < NP; i++) rowbuf_q[i] <= '0;
      vld_q  <= 1'b0;
      pool_q <= '0;
      done_q <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      pair_q   <= pair_d;
      rowbuf_q <= rowbuf_d;
      vld_q    <= vld_d;
      pool_q   <= pool_d;
      done_q   <= done_d;
    end
  end

  assign out_valid  = vld_q;
  assign Out_Pool   = pool_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_ofm_pool_requant.sv
// Directed bench for ofm_pool_requant: every cycle the three outputs are
// compared against hand-derived expectations for the previous cycle's input.
module tb_ofm_pool_requant;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [35:0] In_OFM = '0;
  logic        out_valid;
  logic [15:0] Out_Pool;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  logic        pend_v = 1'b0;
  logic [15:0] pend_o = '0;
  logic        pend_d = 1'b0;

  logic [35:0] vals [36];
  logic [15:0] ex   [9];
  int          oidx [9] = '{7, 9, 11, 19, 21, 23, 31, 33, 35};
  int          wl   [4] = '{0, 4, 8, 5};

  ofm_pool_requant #(.IN_WIDTH(36), .OUT_WIDTH(16), .SHIFT(8), .MAP_W(6)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .In_OFM(In_OFM),
    .out_valid(out_valid), .Out_Pool(Out_Pool), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle: check outputs produced by the previous cycle's input, then drive.
  task automatic cyc(input logic v, input logic [35:0] d, input logic r,
                     input logic ev, input logic [15:0] eo, input logic ed);
    @(negedge clk);
    chk("out_valid", {35'd0, out_valid}, {35'd0, pend_v});
    chk("Out_Pool", {20'd0, Out_Pool}, {20'd0, pend_o});
    chk("frame_done", {35'd0, frame_done}, {35'd0, pend_d});
    rst      = r;
    in_valid = v;
    In_OFM   = d;
    pend_v   = ev;
    pend_o   = ev ? eo : 16'h0;
    pend_d   = ed;
  endtask

  task automatic frame(input int n, input int sa, input int sb);
    int j = 0;
    for (int k = 0; k < n; k++) begin
      logic ev;
      ev = (j < 9) && (k == oidx[j]);
      cyc(1'b1, vals[k], 1'b0, ev, ev ? ex[j] : 16'h0, ev && (k == 35));
      if (ev) j++;
      if (k == sa || k == sb) repeat (3) cyc(1'b0, 36'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 36'h0, 1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 36; k++) vals[k] = 36'(k) << 8;
    for (int j = 0; j < 9; j++) ex[j] = 16'(oidx[j]);
  endtask

  initial begin
    // Reset held with in_valid low
    repeat (10) cyc(1'b0, 36'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(3);

    // Ramp frame
    load_ramp();
    frame(36, -1, -1);
    idle(2);

    // Large value at each window corner in turn, in different windows
    for (int f = 0; f < 4; f++) begin
      int w, k;
      w = wl[f];
      k = (2 * (w / 3) + (f >> 1)) * 6 + 2 * (w % 3) + (f & 1);
      for (int i = 0; i < 36; i++) vals[i] = 36'h1;
      vals[k] = 36'h0_0012_3400;
      for (int j = 0; j < 9; j++) ex[j] = (j == w) ? 16'h1234 : 16'h0000;
      frame(36, -1, -1);
    end
    idle(1);

    // Saturating input, then the largest value that fits exactly
    for (int i = 0; i < 36; i++) vals[i] = 36'hF_FFFF_FFFF;
    for (int j = 0; j < 9; j++) ex[j] = 16'hFFFF;
    frame(36, -1, -1);
    for (int i = 0; i < 36; i++) vals[i] = 36'h0_00FF_FFFF;
    frame(36, -1, -1);
    for (int i = 0; i < 36; i++) vals[i] = 36'h0_0100_0000;
    frame(36, -1, -1);
    idle(2);

    // Stalls inside a frame, then a back-to-back second frame
    load_ramp();
    frame(36, 8, 20);
    frame(36, -1, -1);
    idle(2);

    // Reset mid-frame, then a clean frame
    frame(16, -1, -1);
    cyc(1'b0, 36'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    cyc(1'b0, 36'h0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle(1);
    frame(36, -1, -1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
